// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder slice: default geometry of
// the 64 x 32-bit data RAM, the byte-lane count and the responder state type.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int ADDR_W = 6;           // word-address width, depth = 2**ADDR_W
  localparam int DATA_W = 32;          // word width
  localparam int BE_W   = DATA_W / 8;  // byte lanes per word

  // Responder states. ST_INIT is only entered in builds with the clear sweep.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_resp_if.sv
// -----------------------------------------------------------------------------
// dmem_resp_if
// Request/response channel between an initiator (CPU load/store unit, test
// harness) and the dmem_resp responder.
//   req_valid/req_ready   : request handshake
//   req_write             : 1 = write, 0 = read
//   req_addr              : word address
//   req_wdata, req_be     : write data and byte enables (bit i -> [8i+7:8i])
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata             : read data, or merged word after a write
//   init_done             : memory is available for requests
// Modports: master (initiator side), slave (responder side).
// -----------------------------------------------------------------------------
interface dmem_resp_if
  import dmem_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic [DW/8-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_rdata;
  logic              init_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );

endinterface

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// 2**AW x DW word storage with one shared address: combinational read port and
// synchronous byte-enabled write port. Contents are never reset.
//   clk    : rising-edge clock
//   addr   : word address (read and write)
//   we     : write strobe
//   be     : byte enables for the write
//   wdata  : write data
//   rdata  : combinational read of mem[addr]
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  localparam int LANE_CNT = DW / 8;
  localparam int DEPTH    = 1 << AW;

  logic [DW-1:0] mem_r [DEPTH];

  // Byte-lane write: only enabled lanes of the addressed word are updated.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANE_CNT; i++) begin
      if (we && be[i]) begin
        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp
// Memory-side responder for the data RAM. Accepts word read/write requests on
// a valid/ready channel, performs byte-lane writes, and returns one response
// per request (read data or the merged word after a write) with one-cycle
// latency and full backpressure. Only one response is outstanding at a time.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (drops any pending response)
//   bus    : dmem_resp_if.slave (request, response, init_done)
// Optional build macro DMEM_INIT_CLEAR_EN: after reset the responder sweeps
// zeros into every word (one per cycle) before accepting requests; without it
// there is no sweep and init_done is constantly 1.
// -----------------------------------------------------------------------------
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_resp_if.slave bus
);

  localparam int LANE_CNT = DW / 8;

`ifdef DMEM_INIT_CLEAR_EN
  localparam state_e RST_STATE = ST_INIT;
`else
  localparam state_e RST_STATE = ST_IDLE;
`endif

  state_e               state_r;
  logic                 rsp_valid_r;
  logic [DW-1:0]        rsp_rdata_r;

  logic                 req_ready_s;
  logic                 accept_s;
  logic [DW-1:0]        merged_s;
  logic [DW-1:0]        rsp_load_s;

  logic [AW-1:0]        arr_addr_s;
  logic                 arr_we_s;
  logic [LANE_CNT-1:0]  arr_be_s;
  logic [DW-1:0]        arr_wdata_s;
  logic [DW-1:0]        arr_rdata_s;

`ifdef DMEM_INIT_CLEAR_EN
  logic [AW-1:0]        clr_cnt_r;
  logic                 init_done_r;
`endif

  // Request acceptance: free when idle, or when the pending response is being
  // taken in this same cycle (keeps one request per cycle under Rsp_Ready=1).
  always_comb begin
    req_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: req_ready_s = 1'b1;
      ST_RESP: req_ready_s = bus.rsp_ready;
      ST_INIT: req_ready_s = 1'b0;
      default: req_ready_s = 1'b0;
    endcase
  end

  assign accept_s = bus.req_valid && req_ready_s;

  // Lane merge: the word a write leaves behind, used as its response data.
  always_comb begin
    merged_s = arr_rdata_s;
    for (int i = 0; i < LANE_CNT; i++) begin
      if (bus.req_be[i]) begin
        merged_s[8*i +: 8] = bus.req_wdata[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = arr_rdata_s[8*i +: 8];
      end
    end
  end

  // Response payload for an accepted request.
  always_comb begin
    if (bus.req_write) begin
      rsp_load_s = merged_s;
    end else begin
      rsp_load_s = arr_rdata_s;
    end
  end

  // Array port steering: the clear sweep owns the port while in INIT.
  always_comb begin
    arr_addr_s  = bus.req_addr;
    arr_we_s    = accept_s && bus.req_write;
    arr_be_s    = bus.req_be;
    arr_wdata_s = bus.req_wdata;
`ifdef DMEM_INIT_CLEAR_EN
    if (state_r == ST_INIT) begin
      arr_addr_s  = clr_cnt_r;
      arr_we_s    = 1'b1;
      arr_be_s    = {LANE_CNT{1'b1}};
      arr_wdata_s = {DW{1'b0}};
    end else begin
      arr_addr_s  = bus.req_addr;
      arr_we_s    = accept_s && bus.req_write;
      arr_be_s    = bus.req_be;
      arr_wdata_s = bus.req_wdata;
    end
`endif
  end

  dmem_array #(
    .AW (AW),
    .DW (DW)
  ) u_array (
    .clk   (clk),
    .addr  (arr_addr_s),
    .we    (arr_we_s),
    .be    (arr_be_s),
    .wdata (arr_wdata_s),
    .rdata (arr_rdata_s)
  );

  // Responder FSM with registered response outputs and optional clear sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RST_STATE;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DW{1'b0}};
`ifdef DMEM_INIT_CLEAR_EN
      clr_cnt_r   <= {AW{1'b0}};
      init_done_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_INIT: begin
`ifdef DMEM_INIT_CLEAR_EN
          clr_cnt_r <= clr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
          if (clr_cnt_r == {AW{1'b1}}) begin
            state_r     <= ST_IDLE;
            init_done_r <= 1'b1;
          end else begin
            state_r     <= ST_INIT;
          end
`else
          state_r <= ST_IDLE;
`endif
          rsp_valid_r <= 1'b0;
        end
        ST_IDLE: begin
          if (accept_s) begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= rsp_load_s;
          end else begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
          end
        end
        ST_RESP: begin
          if (accept_s) begin
            // Old response taken and a new one loaded on the same edge.
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= rsp_load_s;
          end else if (bus.rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
          end else begin
            // Backpressure: hold valid and data stable.
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
`ifdef DMEM_INIT_CLEAR_EN
  assign bus.init_done = init_done_r;
`else
  assign bus.init_done = 1'b1;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// -----------------------------------------------------------------------------
// tb_dmem_resp
// Self-checking bench for dmem_resp: directed request sequences with literal
// expectations, plus a request/response model of the memory checked against
// the DUT outputs on every falling clock edge.
// Honours DMEM_INIT_CLEAR_EN the same way the RTL does.
// -----------------------------------------------------------------------------
module tb_dmem_resp;
  import dmem_pkg::*;

`ifdef DMEM_INIT_CLEAR_EN
  localparam int   INIT_CYC   = 64;
  localparam logic RST_READY  = 1'b0;
  localparam logic [31:0] EXP_RD5  = 32'h0000_0000;
  localparam logic [31:0] EXP_RD63 = 32'h0000_0000;
`else
  localparam int   INIT_CYC   = 0;
  localparam logic RST_READY  = 1'b1;
  localparam logic [31:0] EXP_RD5  = 32'h1000_0001;
  localparam logic [31:0] EXP_RD63 = 32'hFCFC_3F3F;
`endif

  logic clk;
  logic rst_n;

  dmem_resp_if bus_if ();

  dmem_resp u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [64];
  logic        mem_k [64];   // word contents known to the model
  logic        m_pend = 1'b0;
  logic [31:0] m_data = 32'h0;
  logic        m_dk   = 1'b0;
  int          init_left = INIT_CYC;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_m[i] = 32'h0;
      mem_k[i] = 1'b0;
    end
  end

  function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [BE_W-1:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (wd & mask);
  endfunction

  function automatic logic [31:0] pattern(input int i);
    return (i * 32'h0101_0101) ^ 32'hC3C3_0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend    <= 1'b0;
      init_left <= INIT_CYC;
    end else if (init_left != 0) begin
      mem_m[64 - init_left] <= 32'h0;
      mem_k[64 - init_left] <= 1'b1;
      init_left <= init_left - 1;
    end else if (bus_if.req_valid && (!m_pend || bus_if.rsp_ready)) begin
      m_pend <= 1'b1;
      if (bus_if.req_write) begin
        m_data <= apply_be(mem_m[bus_if.req_addr], bus_if.req_wdata, bus_if.req_be);
        m_dk   <= mem_k[bus_if.req_addr] || (bus_if.req_be == 4'hF);
        mem_m[bus_if.req_addr] <= apply_be(mem_m[bus_if.req_addr], bus_if.req_wdata, bus_if.req_be);
        mem_k[bus_if.req_addr] <= mem_k[bus_if.req_addr] || (bus_if.req_be == 4'hF);
      end else begin
        m_data <= mem_m[bus_if.req_addr];
        m_dk   <= mem_k[bus_if.req_addr];
      end
    end else if (m_pend && bus_if.rsp_ready) begin
      m_pend <= 1'b0;
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("mdl_rst_valid", {31'h0, bus_if.rsp_valid}, 32'h0);
      chk("mdl_rst_rdata", bus_if.rsp_rdata, 32'h0);
    end else begin
      chk("mdl_init_done", {31'h0, bus_if.init_done}, {31'h0, init_left == 0});
      chk("mdl_req_ready", {31'h0, bus_if.req_ready},
          {31'h0, (init_left == 0) && (!m_pend || bus_if.rsp_ready)});
      chk("mdl_rsp_valid", {31'h0, bus_if.rsp_valid}, {31'h0, m_pend});
      if (m_pend && m_dk) begin
        chk("mdl_rsp_rdata", bus_if.rsp_rdata, m_data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Issue one request (starting just after a rising edge) and check the
  // response one cycle after the accept edge.
  task automatic send(input logic w, input logic [5:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] exp, input string name);
    bit got;
    bus_if.req_valid = 1'b1;
    bus_if.req_write = w;
    bus_if.req_addr  = a;
    bus_if.req_wdata = d;
    bus_if.req_be    = be;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus_if.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: req_ready got 0 expected 1", name);
    end
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, {31'h0, bus_if.rsp_valid}, 32'h1);
    chk({name, "_data"}, bus_if.rsp_rdata, exp);
    @(posedge clk);
    #1;
  endtask

  // Release reset and count falling edges with req_ready low (the clear sweep).
  task automatic release_reset(input string name);
    int cnt;
    bit got;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus_if.req_ready) begin
        got = 1'b1;
        break;
      end
      cnt++;
    end
    chk({name, "_init_cycles"}, cnt, INIT_CYC);
    chk({name, "_ready_seen"}, {31'h0, got}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_rsp;
    logic [31:0] last63;
    logic [31:0] wrap0;

    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = 6'd0;
    bus_if.req_wdata = 32'h0;
    bus_if.req_be    = 4'h0;
    bus_if.rsp_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rsp_valid", {31'h0, bus_if.rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", bus_if.rsp_rdata, 32'h0);
    chk("rst_req_ready", {31'h0, bus_if.req_ready}, {31'h0, RST_READY});
    chk("rst_init_done", {31'h0, bus_if.init_done}, {31'h0, RST_READY});
    repeat (2) @(posedge clk);
    release_reset("boot");

    // Full-word write then read back.
    send(1'b1, 6'd5, 32'h1000_0001, 4'hF, 32'h1000_0001, "wr5");
    send(1'b0, 6'd5, 32'h0,         4'h0, 32'h1000_0001, "rd5");

    // Partial-lane write merges with the old word; BE=0 leaves it intact.
    send(1'b1, 6'd3, 32'h7FFF_FFFF, 4'hF,    32'h7FFF_FFFF, "wr3_full");
    send(1'b1, 6'd3, 32'h8000_1111, 4'b0011, 32'h7FFF_1111, "wr3_half");
    send(1'b0, 6'd3, 32'h0,         4'h0,    32'h7FFF_1111, "rd3");
    send(1'b1, 6'd3, 32'hDEAD_BEEF, 4'h0,    32'h7FFF_1111, "wr3_be0");
    send(1'b0, 6'd3, 32'h0,         4'h0,    32'h7FFF_1111, "rd3_after_be0");

    // Back-to-back write then read of the same address.
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b1;
    bus_if.req_addr  = 6'd9;
    bus_if.req_wdata = 32'h1234_5678;
    bus_if.req_be    = 4'hF;
    @(posedge clk); #1;
    bus_if.req_write = 1'b0;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    chk("raw9_data", bus_if.rsp_rdata, 32'h1234_5678);
    @(posedge clk); #1;

    // Backpressure: response held three extra cycles, then taken with a new accept.
    bus_if.rsp_ready = 1'b0;
    send(1'b1, 6'd7, 32'hA5A5_5A5A, 4'hF, 32'hA5A5_5A5A, "bp_wr7");
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = 6'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'h0, bus_if.rsp_valid}, 32'h1);
      chk("bp_hold_data",  bus_if.rsp_rdata, 32'hA5A5_5A5A);
      chk("bp_hold_ready", {31'h0, bus_if.req_ready}, 32'h0);
    end
    @(posedge clk); #1;
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'h0, bus_if.req_ready}, 32'h1);
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", {31'h0, bus_if.rsp_valid}, 32'h1);
    chk("bp_next_data",  bus_if.rsp_rdata, 32'h7FFF_1111);
    @(posedge clk); #1;

    // Streaming: write every word, then read 0..63 and wrap to 0, no bubbles.
    for (int i = 0; i < 64; i++) begin
      bus_if.req_valid = 1'b1;
      bus_if.req_write = 1'b1;
      bus_if.req_addr  = 6'(i);
      bus_if.req_wdata = pattern(i);
      bus_if.req_be    = 4'hF;
      @(posedge clk); #1;
    end
    n_rsp  = 0;
    last63 = 32'h0;
    for (int i = 0; i <= 64; i++) begin
      bus_if.req_write = 1'b0;
      bus_if.req_addr  = 6'(i);
      @(negedge clk);
      if (i > 0 && bus_if.rsp_valid) n_rsp++;
      if (i == 64) last63 = bus_if.rsp_rdata;
      @(posedge clk); #1;
    end
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    if (bus_if.rsp_valid) n_rsp++;
    wrap0 = bus_if.rsp_rdata;
    @(posedge clk); #1;
    chk("stream_rsp_count", n_rsp, 65);
    chk("stream_addr63", last63, 32'hFCFC_3F3F);
    chk("stream_wrap0",  wrap0,  32'hC3C3_0000);

    // Asynchronous reset while a response is pending.
    send(1'b1, 6'd5, 32'h1000_0001, 4'hF, 32'h1000_0001, "pre_rst_wr5");
    bus_if.rsp_ready = 1'b0;
    send(1'b0, 6'd5, 32'h0, 4'h0, 32'h1000_0001, "pre_rst_rd5");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, bus_if.rsp_valid}, 32'h0);
    chk("async_rst_rdata", bus_if.rsp_rdata, 32'h0);
    bus_if.rsp_ready = 1'b1;
    release_reset("rerun");
    send(1'b0, 6'd5,  32'h0, 4'h0, EXP_RD5,  "post_rst_rd5");
    send(1'b0, 6'd63, 32'h0, 4'h0, EXP_RD63, "post_rst_rd63");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got %0t expected below 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
